// File: rtl/csr_access_sequencer_pkg.sv
// rtl/csr_access_sequencer_pkg.sv - shared types and constants for the CSR access sequencer
// Holds the sequencer state enum, CSR op encodings, supervisor CSR addresses,
// sstatus bit positions and the sstatus trap-entry update helper.
package csr_access_sequencer_pkg;

  typedef enum logic [3:0] {
    IDLE,
    C_RD,
    C_WR,
    T_EPC,
    T_CAUSE,
    T_TVAL,
    T_SRD,
    T_SWR,
    T_VEC
  } state_t;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  localparam logic [11:0] CSR_SSTATUS = 12'h100;
  localparam logic [11:0] CSR_STVEC   = 12'h105;
  localparam logic [11:0] CSR_SEPC    = 12'h141;
  localparam logic [11:0] CSR_SCAUSE  = 12'h142;
  localparam logic [11:0] CSR_STVAL   = 12'h143;

  localparam int SSTATUS_SIE  = 1;
  localparam int SSTATUS_SPIE = 5;
  localparam int SSTATUS_SPP  = 8;

  // Trap entry: stash SIE into SPIE, mask interrupts, record the prior privilege.
  function automatic logic [31:0] sstatus_on_trap(input logic [31:0] old_val,
                                                  input logic        spp);
    logic [31:0] v;
    v               = old_val;
    v[SSTATUS_SPIE] = old_val[SSTATUS_SIE];
    v[SSTATUS_SIE]  = 1'b0;
    v[SSTATUS_SPP]  = spp;
    return v;
  endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// rtl/csr_rmw_alu.sv - combinational read-modify-write value and write-enable for CSR ops
// Ports:
//   op       in  2   CSR op (READ/RW/RS/RC)
//   old_val  in  32  current CSR contents
//   src      in  32  rs1/uimm operand
//   src_zero in  1   rs1/uimm field is zero (RS/RC then do not write)
//   new_val  out 32  value to write back
//   wr_en    out 1   write-back required
module csr_rmw_alu
  import csr_access_sequencer_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] old_val,
  input  logic [31:0] src,
  input  logic        src_zero,
  output logic [31:0] new_val,
  output logic        wr_en
);

  always_comb begin
    new_val = old_val;
    wr_en   = 1'b0;
    case (op)
      OP_RW: begin
        new_val = src;
        wr_en   = 1'b1;
      end
      OP_RS: begin
        new_val = old_val | src;
        wr_en   = ~src_zero;
      end
      OP_RC: begin
        new_val = old_val & ~src;
        wr_en   = ~src_zero;
      end
      default: begin
        new_val = old_val;
        wr_en   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_access_sequencer.sv
// rtl/csr_access_sequencer.sv - sequences CSR instruction accesses and trap-entry CSR updates
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_req_valid/o_req_ready        CSR instruction handshake (ready only in IDLE)
//   i_req_op/addr/src/src_zero     CSR op, address, operand, operand-is-zero
//   i_trap_valid, i_trap_*         trap request with cause/tval/pc/prior privilege
//   o_csr_select/data/load         CSR-file port; i_csr_regout is its combinational read
//   o_done                         one-cycle completion pulse
//   o_rd_data                      old CSR value of the last CSR op (held)
//   o_trap_pc                      stvec target of the last trap (held)
//   o_illegal                      illegal-access flag, pulses with o_done
// Build option: CSR_RO_CHECK_EN rejects writes to read-only CSRs (addr[11:10]==2'b11).
// o_trap_pc is driven straight from i_csr_regout during T_VEC so the target is
// visible alongside o_done; it is then registered and held.
module csr_access_sequencer
  import csr_access_sequencer_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [1:0]  i_req_op,
  input  logic [11:0] i_req_addr,
  input  logic [31:0] i_req_src,
  input  logic        i_req_src_zero,
  input  logic        i_trap_valid,
  input  logic [31:0] i_trap_cause,
  input  logic [31:0] i_trap_tval,
  input  logic [31:0] i_trap_pc,
  input  logic        i_trap_spp,
  output logic [11:0] o_csr_select,
  output logic [31:0] o_csr_data,
  output logic        o_csr_load,
  input  logic [31:0] i_csr_regout,
  output logic        o_done,
  output logic [31:0] o_rd_data,
  output logic [31:0] o_trap_pc,
  output logic        o_illegal
);

  state_t      state;
  logic        ready_q;
  logic [11:0] sel_q;
  logic [31:0] data_q;
  logic        load_q;
  logic        done_q;
  logic        illegal_q;
  logic [31:0] rd_data_q;
  logic [31:0] trap_pc_q;

  logic [1:0]  op_q;
  logic [11:0] addr_q;
  logic [31:0] src_q;
  logic        zero_q;
  logic [31:0] cause_q;
  logic [31:0] tval_q;
  logic        spp_q;

  logic [31:0] alu_new;
  logic        alu_we;
  logic        ro_block;

  // During C_RD the CSR file is reading addr_q, so regout is the old value.
  csr_rmw_alu u_rmw (
    .op       (op_q),
    .old_val  (i_csr_regout),
    .src      (src_q),
    .src_zero (zero_q),
    .new_val  (alu_new),
    .wr_en    (alu_we)
  );

`ifdef CSR_RO_CHECK_EN
  assign ro_block = alu_we & (addr_q[11:10] == 2'b11);
`else
  assign ro_block = 1'b0;
`endif

  // Outputs are registered for the state being entered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      ready_q   <= 1'b1;
      sel_q     <= '0;
      data_q    <= '0;
      load_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      rd_data_q <= '0;
      trap_pc_q <= '0;
      op_q      <= OP_READ;
      addr_q    <= '0;
      src_q     <= '0;
      zero_q    <= 1'b0;
      cause_q   <= '0;
      tval_q    <= '0;
      spp_q     <= 1'b0;
    end else begin
      load_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state)
        IDLE: begin
          // Trap has priority; a concurrent CSR request is left pending.
          if (i_trap_valid) begin
            state   <= T_EPC;
            ready_q <= 1'b0;
            cause_q <= i_trap_cause;
            tval_q  <= i_trap_tval;
            spp_q   <= i_trap_spp;
            sel_q   <= CSR_SEPC;
            data_q  <= i_trap_pc;
            load_q  <= 1'b1;
          end else if (i_req_valid) begin
            state   <= C_RD;
            ready_q <= 1'b0;
            op_q    <= i_req_op;
            addr_q  <= i_req_addr;
            src_q   <= i_req_src;
            zero_q  <= i_req_src_zero;
            sel_q   <= i_req_addr;
            data_q  <= '0;
          end
        end
        C_RD: begin
          state     <= C_WR;
          data_q    <= alu_new;
          load_q    <= alu_we & ~ro_block;
          illegal_q <= ro_block;
          done_q    <= 1'b1;
          rd_data_q <= i_csr_regout;
        end
        C_WR: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          sel_q   <= '0;
          data_q  <= '0;
        end
        T_EPC: begin
          state  <= T_CAUSE;
          sel_q  <= CSR_SCAUSE;
          data_q <= cause_q;
          load_q <= 1'b1;
        end
        T_CAUSE: begin
          state  <= T_TVAL;
          sel_q  <= CSR_STVAL;
          data_q <= tval_q;
          load_q <= 1'b1;
        end
        T_TVAL: begin
          state  <= T_SRD;
          sel_q  <= CSR_SSTATUS;
          data_q <= '0;
        end
        T_SRD: begin
          state  <= T_SWR;
          data_q <= sstatus_on_trap(i_csr_regout, spp_q);
          load_q <= 1'b1;
        end
        T_SWR: begin
          state  <= T_VEC;
          sel_q  <= CSR_STVEC;
          data_q <= '0;
          done_q <= 1'b1;
        end
        T_VEC: begin
          state     <= IDLE;
          ready_q   <= 1'b1;
          sel_q     <= '0;
          trap_pc_q <= {i_csr_regout[31:2], 2'b00};
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          sel_q   <= '0;
          data_q  <= '0;
        end
      endcase
    end
  end

  assign o_req_ready  = ready_q;
  assign o_csr_select = sel_q;
  assign o_csr_data   = data_q;
  assign o_csr_load   = load_q;
  assign o_done       = done_q;
  assign o_illegal    = illegal_q;
  assign o_rd_data    = rd_data_q;
  assign o_trap_pc    = (state == T_VEC) ? {i_csr_regout[31:2], 2'b00} : trap_pc_q;

endmodule

// File: tb/tb_csr_access_sequencer.sv
// tb/tb_csr_access_sequencer.sv - self-checking bench for csr_access_sequencer
module tb_csr_access_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [1:0]  i_req_op = 2'b00;
  logic [11:0] i_req_addr = '0;
  logic [31:0] i_req_src = '0;
  logic        i_req_src_zero = 1'b0;
  logic        i_trap_valid = 1'b0;
  logic [31:0] i_trap_cause = '0;
  logic [31:0] i_trap_tval = '0;
  logic [31:0] i_trap_pc = '0;
  logic        i_trap_spp = 1'b0;
  logic [11:0] o_csr_select;
  logic [31:0] o_csr_data;
  logic        o_csr_load;
  logic [31:0] i_csr_regout;
  logic        o_done;
  logic [31:0] o_rd_data;
  logic [31:0] o_trap_pc;
  logic        o_illegal;

  csr_access_sequencer dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_op       (i_req_op),
    .i_req_addr     (i_req_addr),
    .i_req_src      (i_req_src),
    .i_req_src_zero (i_req_src_zero),
    .i_trap_valid   (i_trap_valid),
    .i_trap_cause   (i_trap_cause),
    .i_trap_tval    (i_trap_tval),
    .i_trap_pc      (i_trap_pc),
    .i_trap_spp     (i_trap_spp),
    .o_csr_select   (o_csr_select),
    .o_csr_data     (o_csr_data),
    .o_csr_load     (o_csr_load),
    .i_csr_regout   (i_csr_regout),
    .o_done         (o_done),
    .o_rd_data      (o_rd_data),
    .o_trap_pc      (o_trap_pc),
    .o_illegal      (o_illegal)
  );

  always #5 i_clk = ~i_clk;

  // CSR file stand-in: combinational read, write on load at the clock edge.
  logic [31:0] mem [0:4095];
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_val = '0;
  assign i_csr_regout = mem[o_csr_select];

  always @(posedge i_clk) begin
    if (pre_en) mem[pre_addr] <= pre_val;
    else if (o_csr_load) mem[o_csr_select] <= o_csr_data;
  end

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  logic [11:0] ld_addr[$];
  logic [31:0] ld_data[$];
  always @(negedge i_clk) begin
    if (o_csr_load) begin
      ld_addr.push_back(o_csr_select);
      ld_data.push_back(o_csr_data);
    end
  end

  int passed = 0;
  int total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    else passed++;
  endtask

  task automatic preset(input logic [11:0] a, input logic [31:0] v);
    @(negedge i_clk);
    pre_en = 1'b1; pre_addr = a; pre_val = v;
    @(posedge i_clk);
    #1 pre_en = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] src;
    logic        zero;
    logic [31:0] old;
    logic        exp_load;
    logic [31:0] exp_data;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[8];

  task automatic run_csr(input vec_t v);
    int acc, base;
    logic got;
    preset(v.addr, v.old);
    @(negedge i_clk);
    chk("csr_ready_idle", 32'(o_req_ready), 32'd1);
    i_req_valid = 1'b1; i_req_op = v.op; i_req_addr = v.addr;
    i_req_src = v.src; i_req_src_zero = v.zero;
    acc = cyc; base = ld_addr.size();
    @(negedge i_clk);
    i_req_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (o_done) begin got = 1'b1; break; end
      @(negedge i_clk);
    end
    chk("csr_done_seen", 32'(got), 32'd1);
    chk("csr_latency", 32'(cyc - acc), 32'd2);
    chk("csr_rd_data", o_rd_data, v.old);
    chk("csr_illegal", 32'(o_illegal), 32'(v.exp_ill));
    @(negedge i_clk);
    chk("csr_done_pulse", 32'(o_done), 32'd0);
    chk("csr_rd_hold", o_rd_data, v.old);
    chk("csr_load_count", 32'(ld_addr.size() - base), 32'(v.exp_load));
    if (v.exp_load && ld_addr.size() > base) begin
      chk("csr_load_addr", 32'(ld_addr[base]), 32'(v.addr));
      chk("csr_load_data", ld_data[base], v.exp_data);
    end
  endtask

  task automatic wait_done(output int at);
    logic got;
    got = 1'b0;
    at = cyc;
    for (int k = 0; k < 24; k++) begin
      if (o_done) begin got = 1'b1; at = cyc; break; end
      @(negedge i_clk);
    end
    chk("done_seen", 32'(got), 32'd1);
  endtask

  initial begin
    int acc, acc2, base, at;
    logic [11:0] ea[5];
    logic [31:0] ed[5];

    vecs[0] = '{2'b01, 12'h140, 32'hDEADBEEF, 1'b0, 32'h12,       1'b1, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{2'b10, 12'h104, 32'h0,        1'b1, 32'h22,       1'b0, 32'h0,        1'b0};
    vecs[2] = '{2'b11, 12'h104, 32'h2,        1'b0, 32'h22,       1'b1, 32'h20,       1'b0};
    vecs[3] = '{2'b10, 12'h105, 32'h00000F00, 1'b0, 32'h000000F0, 1'b1, 32'h00000FF0, 1'b0};
    vecs[4] = '{2'b00, 12'h141, 32'h55,       1'b0, 32'hABCD,     1'b0, 32'h0,        1'b0};
    vecs[5] = '{2'b11, 12'h142, 32'h0,        1'b1, 32'hFFFF,     1'b0, 32'h0,        1'b0};
    vecs[6] = '{2'b01, 12'h143, 32'h0,        1'b1, 32'h7,        1'b1, 32'h0,        1'b0};
`ifdef CSR_RO_CHECK_EN
    vecs[7] = '{2'b01, 12'hC01, 32'h1111,     1'b0, 32'h9,        1'b0, 32'h0,        1'b1};
`else
    vecs[7] = '{2'b01, 12'hC01, 32'h1111,     1'b0, 32'h9,        1'b1, 32'h1111,     1'b0};
`endif

    // Reset state
    repeat (2) @(negedge i_clk);
    chk("rst_load", 32'(o_csr_load), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_illegal", 32'(o_illegal), 32'd0);
    chk("rst_rd_data", o_rd_data, 32'd0);
    chk("rst_trap_pc", o_trap_pc, 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rst_ready", 32'(o_req_ready), 32'd1);

    // Table-driven CSR ops
    for (int i = 0; i < 8; i++) run_csr(vecs[i]);

    // Trap entry: sstatus 0x2 (SIE) with spp=1 -> SPIE|SPP = 0x120
    preset(12'h100, 32'h2);
    preset(12'h105, 32'h80000103);
    @(negedge i_clk);
    i_trap_valid = 1'b1; i_trap_pc = 32'h80001000; i_trap_cause = 32'hD;
    i_trap_tval = 32'h1234; i_trap_spp = 1'b1;
    acc = cyc; base = ld_addr.size();
    @(negedge i_clk);
    i_trap_valid = 1'b0;
    wait_done(at);
    chk("trap_latency", 32'(at - acc), 32'd6);
    chk("trap_pc", o_trap_pc, 32'h80000100);
    @(negedge i_clk);
    chk("trap_done_pulse", 32'(o_done), 32'd0);
    chk("trap_pc_hold", o_trap_pc, 32'h80000100);
    chk("trap_load_count", 32'(ld_addr.size() - base), 32'd4);
    ea = '{12'h141, 12'h142, 12'h143, 12'h100, 12'h0};
    ed = '{32'h80001000, 32'hD, 32'h1234, 32'h120, 32'h0};
    for (int i = 0; i < 4; i++) begin
      if (ld_addr.size() > base + i) begin
        chk("trap_load_addr", 32'(ld_addr[base+i]), 32'(ea[i]));
        chk("trap_load_data", ld_data[base+i], ed[i]);
      end
    end

    // Trap and CSR request together: trap first, CSR afterwards
    preset(12'h100, 32'h2);
    preset(12'h105, 32'h40000002);
    preset(12'h140, 32'h77);
    @(negedge i_clk);
    i_trap_valid = 1'b1; i_trap_pc = 32'h80002000; i_trap_cause = 32'h8;
    i_trap_tval = 32'h0; i_trap_spp = 1'b0;
    i_req_valid = 1'b1; i_req_op = 2'b01; i_req_addr = 12'h140;
    i_req_src = 32'h5; i_req_src_zero = 1'b0;
    acc = cyc; base = ld_addr.size();
    @(negedge i_clk);
    i_trap_valid = 1'b0;
    wait_done(at);
    chk("both_trap_latency", 32'(at - acc), 32'd6);
    chk("both_trap_pc", o_trap_pc, 32'h40000000);
    acc2 = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (o_req_ready && i_req_valid) begin
        acc2 = cyc;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        break;
      end
    end
    chk("both_csr_accepted", 32'(i_req_valid), 32'd0);
    wait_done(at);
    chk("both_csr_latency", 32'(at - acc2), 32'd2);
    chk("both_csr_rd_data", o_rd_data, 32'h77);
    @(negedge i_clk);
    chk("both_trap_pc_hold", o_trap_pc, 32'h40000000);
    chk("both_load_count", 32'(ld_addr.size() - base), 32'd5);
    ea = '{12'h141, 12'h142, 12'h143, 12'h100, 12'h140};
    ed = '{32'h80002000, 32'h8, 32'h0, 32'h20, 32'h5};
    for (int i = 0; i < 5; i++) begin
      if (ld_addr.size() > base + i) begin
        chk("both_load_addr", 32'(ld_addr[base+i]), 32'(ea[i]));
        chk("both_load_data", ld_data[base+i], ed[i]);
      end
    end

    // Reset asserted while in T_CAUSE
    @(negedge i_clk);
    i_trap_valid = 1'b1; i_trap_pc = 32'h1000; i_trap_cause = 32'h2;
    i_trap_tval = 32'h3; i_trap_spp = 1'b0;
    @(posedge i_clk);
    #1 i_trap_valid = 1'b0;
    @(posedge i_clk);
    #1 i_rst_n = 1'b0;
    base = ld_addr.size();
    #1;
    chk("midrst_load", 32'(o_csr_load), 32'd0);
    chk("midrst_trap_pc", o_trap_pc, 32'd0);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (6) @(negedge i_clk);
    chk("midrst_no_loads", 32'(ld_addr.size() - base), 32'd0);
    chk("midrst_ready", 32'(o_req_ready), 32'd1);
    chk("midrst_done", 32'(o_done), 32'd0);
    chk("midrst_epc_kept", mem[12'h141], 32'h1000);
    chk("midrst_cause_untouched", mem[12'h142], 32'h8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
